// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec SPI configuration sequencer: FSM state
// encoding and the SPI frame width helper.
package codec_cfg_pkg;

   typedef enum logic [3:0] {
      StHoldRst,
      StBoot,
      StLoad,
      StWr,
      StGap,
      StRd,
      StCmp,
      StNext,
      StDone,
      StErr
   } state_e;

   // Frame layout is {address, r/w bit, data}.
   function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
      return addr_w + 1 + data_w;
   endfunction

endpackage

// File: rtl/codec_spi_shifter.sv
// SPI mode-0 frame engine: SCLK divider, half-period counter and tx/rx shift
// registers for one FW-bit frame per start pulse.
module codec_spi_shifter #(
   parameter int unsigned FW      = 16,
   parameter int unsigned CLK_DIV = 25
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [FW-1:0] tx_i,
   output logic [FW-1:0] rx_o,
   output logic          done_o,
   output logic          cs_n_o,
   output logic          sclk_o,
   output logic          mosi_o,
   input  logic          miso_i
);

   localparam int unsigned HalfW = $clog2(2 * FW + 1) + 1;
   localparam int unsigned DivW  = $clog2(CLK_DIV) + 1;

   logic             active_q, active_d;
   logic [DivW-1:0]  div_q, div_d;
   logic [HalfW-1:0] half_q, half_d;
   logic [FW-1:0]    tx_q, tx_d;
   logic [FW-1:0]    rx_q, rx_d;
   logic             cs_n_q, cs_n_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             tick;

   always_comb begin
      active_d = active_q;
      div_d    = div_q;
      half_d   = half_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      done_o   = 1'b0;
      tick     = (div_q == DivW'(CLK_DIV - 1));

      if (!active_q) begin
         if (start_i) begin
            active_d = 1'b1;
            cs_n_d   = 1'b0;
            sclk_d   = 1'b0;
            tx_d     = tx_i;
            mosi_d   = tx_i[FW-1];
            div_d    = '0;
            half_d   = '0;
         end
      end else if (tick) begin
         div_d  = '0;
         half_d = half_q + HalfW'(1);
         // Expiries alternate rise/fall; the one after the last fall ends the frame.
         if (half_q == HalfW'(2 * FW)) begin
            active_d = 1'b0;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            half_d   = '0;
            done_o   = 1'b1;
         end else if (!half_q[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[FW-2:0], miso_i};
         end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[FW-2:0], 1'b0};
            mosi_d = tx_q[FW-2];
         end
      end else begin
         div_d = div_q + DivW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         div_q    <= '0;
         half_q   <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         div_q    <= div_d;
         half_q   <= half_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         cs_n_q   <= cs_n_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

   assign rx_o   = rx_q;
   assign cs_n_o = cs_n_q;
   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;

endmodule

// File: rtl/codec_spi_cfg_seq.sv
// Codec bring-up sequencer: holds the codec in reset, waits for boot, then
// writes (and optionally read-verifies) every table entry over SPI.
module codec_spi_cfg_seq
   import codec_cfg_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CLK_DIV     = 25,
   parameter int unsigned RST_CYCLES  = 1048575,
   parameter int unsigned BOOT_CYCLES = 4096,
   parameter int unsigned VERIFY      = 1,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic              CLK_50MHZ,
   input  logic              RESET,
   input  logic              start,
   output logic [7:0]        tbl_idx,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [DATA_W-1:0] tbl_data,
   output logic              codec_rst_n,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        err_idx
);

   localparam int unsigned FW = frame_w(ADDR_W, DATA_W);

   state_e            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        attempt_q, attempt_d;
   logic [7:0]        err_idx_q, err_idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rd_q, rd_d;
   logic              sent_q, sent_d;
   logic              codec_rst_n_q, codec_rst_n_d;

   logic              sh_start;
   logic              sh_done;
   logic [FW-1:0]     sh_tx;
   logic [FW-1:0]     sh_rx;
   logic              unused_rx;

   codec_spi_shifter #(
      .FW      (FW),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk_i   (CLK_50MHZ),
      .rst_i   (RESET),
      .start_i (sh_start),
      .tx_i    (sh_tx),
      .rx_o    (sh_rx),
      .done_o  (sh_done),
      .cs_n_o  (spi_cs_n),
      .sclk_o  (spi_sclk),
      .mosi_o  (spi_mosi),
      .miso_i  (spi_miso)
   );

   // Address and r/w bits echoed during a read frame are not checked.
   assign unused_rx = ^sh_rx[FW-1:DATA_W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      attempt_d = attempt_q;
      err_idx_d = err_idx_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rd_d      = rd_q;
      sent_d    = sent_q;
      sh_start  = 1'b0;
      sh_tx     = {addr_q, 1'b0, data_q};

      unique case (state_q)
         StHoldRst: begin
            if (cnt_q == RST_CYCLES - 1) begin
               state_d = StBoot;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StBoot: begin
            if (cnt_q == BOOT_CYCLES - 1) begin
               state_d = StLoad;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StLoad: begin
            state_d = StWr;
            sent_d  = 1'b0;
         end
         StWr: begin
            // Table output is valid here, one cycle after tbl_idx was presented.
            if (!sent_q) begin
               sh_start = 1'b1;
               sent_d   = 1'b1;
               addr_d   = tbl_addr;
               data_d   = tbl_data;
               sh_tx    = {tbl_addr, 1'b0, tbl_data};
            end else if (sh_done) begin
               sent_d  = 1'b0;
               rd_d    = 1'b0;
               cnt_d   = '0;
               state_d = StGap;
            end
         end
         StRd: begin
            if (!sent_q) begin
               sh_start = 1'b1;
               sent_d   = 1'b1;
               sh_tx    = {addr_q, 1'b1, {DATA_W{1'b0}}};
            end else if (sh_done) begin
               sent_d  = 1'b0;
               rd_d    = 1'b1;
               cnt_d   = '0;
               state_d = StGap;
            end
         end
         StGap: begin
            if (cnt_q == 2 * CLK_DIV - 1) begin
               cnt_d = '0;
               if (rd_q) begin
                  state_d = StCmp;
               end else if (VERIFY != 0) begin
                  state_d = StRd;
               end else begin
                  state_d = StNext;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StCmp: begin
            if (sh_rx[DATA_W-1:0] == data_q) begin
               state_d = StNext;
            end else if (attempt_q == 8'(MAX_RETRY - 1)) begin
               err_idx_d = idx_q;
               state_d   = StErr;
            end else begin
               attempt_d = attempt_q + 8'd1;
               state_d   = StWr;
            end
         end
         StNext: begin
            attempt_d = '0;
            if (idx_q == 8'(NUM_REGS - 1)) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = StLoad;
            end
         end
         StDone, StErr: begin
            if (start) begin
               idx_d     = '0;
               attempt_d = '0;
               cnt_d     = '0;
               state_d   = StLoad;
            end
         end
         default: state_d = StHoldRst;
      endcase

      codec_rst_n_d = (state_d != StHoldRst);
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (RESET) begin
         state_q       <= StHoldRst;
         cnt_q         <= '0;
         idx_q         <= '0;
         attempt_q     <= '0;
         err_idx_q     <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         rd_q          <= 1'b0;
         sent_q        <= 1'b0;
         codec_rst_n_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         attempt_q     <= attempt_d;
         err_idx_q     <= err_idx_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         rd_q          <= rd_d;
         sent_q        <= sent_d;
         codec_rst_n_q <= codec_rst_n_d;
      end
   end

   assign tbl_idx     = idx_q;
   assign err_idx     = err_idx_q;
   assign codec_rst_n = codec_rst_n_q;
   assign busy        = (state_q != StDone) && (state_q != StErr);
   assign done        = (state_q == StDone);
   assign error       = (state_q == StErr);

endmodule

// File: tb/tb_codec_spi_cfg_seq.sv
// Directed bench for codec_spi_cfg_seq: echoing SPI slave model, frame
// scoreboard, reset timing, retry exhaustion, mid-frame reset and restart.
module tb_codec_spi_cfg_seq;

   localparam int unsigned NREG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, slave_fault;
   logic [7:0] tbl_idx, err_idx;
   logic [6:0] tbl_addr;
   logic [7:0] tbl_data;
   logic       codec_rst_n, cs_n, sclk, mosi, miso, busy, done, error;

   logic [7:0] nv_tbl_idx, nv_err_idx;
   logic       nv_start = 1'b0;
   logic       nv_rst_n, nv_cs_n, nv_sclk, nv_mosi, nv_busy, nv_done, nv_error;

   logic [6:0] t_addr [NREG] = '{7'h0B, 7'h22, 7'h55};
   logic [7:0] t_data [NREG] = '{8'hA5, 8'h3C, 8'h0F};

   int unsigned nchecks = 0;
   int unsigned nerrors = 0;

   codec_spi_cfg_seq #(
      .NUM_REGS(NREG), .ADDR_W(7), .DATA_W(8), .CLK_DIV(2), .RST_CYCLES(16),
      .BOOT_CYCLES(8), .VERIFY(1), .MAX_RETRY(3)
   ) u_dut (
      .CLK_50MHZ(clk), .RESET(rst), .start(start), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .codec_rst_n(codec_rst_n), .spi_cs_n(cs_n), .spi_sclk(sclk),
      .spi_mosi(mosi), .spi_miso(miso), .busy(busy), .done(done), .error(error),
      .err_idx(err_idx)
   );

   // Single-entry, no-verify, fastest-SCLK instance with MISO stuck low.
   codec_spi_cfg_seq #(
      .NUM_REGS(1), .ADDR_W(7), .DATA_W(8), .CLK_DIV(1), .RST_CYCLES(4),
      .BOOT_CYCLES(2), .VERIFY(0), .MAX_RETRY(3)
   ) u_nv (
      .CLK_50MHZ(clk), .RESET(rst), .start(nv_start), .tbl_idx(nv_tbl_idx),
      .tbl_addr(7'h11), .tbl_data(8'h5A), .codec_rst_n(nv_rst_n), .spi_cs_n(nv_cs_n),
      .spi_sclk(nv_sclk), .spi_mosi(nv_mosi), .spi_miso(1'b0), .busy(nv_busy),
      .done(nv_done), .error(nv_error), .err_idx(nv_err_idx)
   );

   always @(posedge clk) begin
      if (tbl_idx < 8'(NREG)) begin
         tbl_addr <= t_addr[tbl_idx[1:0]];
         tbl_data <= t_data[tbl_idx[1:0]];
      end else begin
         tbl_addr <= '0;
         tbl_data <= '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp)
      else begin
         nerrors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fr(input logic [6:0] a, input logic rw, input logic [7:0] d);
      return {a, rw, rw ? 8'h00 : d};
   endfunction

   // SPI slave: register file that echoes writes, optionally corrupting entry 1 reads.
   logic [7:0]  mem [128];
   logic [15:0] s_sh;
   int          s_cnt;
   logic [6:0]  s_addr;
   logic        s_rw;
   logic [7:0]  reply;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      miso = 1'b0;
      s_cnt = 0;
      s_rw = 1'b0;
      s_sh = '0;
      s_addr = '0;
   end
   initial forever begin
      @(negedge cs_n);
      s_cnt = 0; s_sh = '0; s_rw = 1'b0; miso = 1'b0;
   end
   initial forever begin
      @(posedge sclk);
      if (!cs_n) begin
         s_sh = {s_sh[14:0], mosi};
         s_cnt++;
         if (s_cnt == 8) begin
            s_addr = s_sh[7:1];
            s_rw   = s_sh[0];
         end
      end
   end
   initial forever begin
      @(negedge sclk);
      if (!cs_n && s_rw && s_cnt >= 8 && s_cnt < 16) begin
         reply = (slave_fault && s_addr == 7'h22) ? 8'h00 : mem[s_addr];
         miso  = reply[7 - (s_cnt - 8)];
      end
   end
   initial forever begin
      @(posedge cs_n);
      if (s_cnt == 16 && !s_rw) mem[s_addr] = s_sh[7:0];
      miso = 1'b0;
   end

   // Frame monitor and scoreboard, sampled on the falling clock edge.
   logic [15:0] exp_q [$];
   logic [15:0] cap, exp_frame, nv_cap;
   int          pulses, cs_low, frames_seen, nv_frames;
   logic        cs_prev = 1'b1, sclk_prev = 1'b0, nv_cs_prev = 1'b1, nv_sclk_prev = 1'b0;
   logic        abort_frame = 1'b0, rst_low_seen = 1'b0;

   initial begin
      cap = '0; pulses = 0; cs_low = 0; frames_seen = 0; nv_frames = 0; nv_cap = '0;
      forever begin
         @(negedge clk);
         if (!cs_n && cs_prev) begin
            cap = '0; pulses = 0; cs_low = 0;
         end
         if (!cs_n) cs_low++;
         if (!cs_n && sclk && !sclk_prev) begin
            cap = {cap[14:0], mosi};
            pulses++;
         end
         if (cs_n && !cs_prev) begin
            if (abort_frame) begin
               abort_frame = 1'b0;
            end else begin
               frames_seen++;
               check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  exp_frame = exp_q.pop_front();
                  check("frame_bits", 32'(cap), 32'(exp_frame));
                  check("frame_pulses", pulses, 16);
                  check("frame_cs_low", cs_low, 66);
               end
            end
         end
         if (!codec_rst_n) rst_low_seen = 1'b1;
         cs_prev = cs_n;
         sclk_prev = sclk;
         if (!nv_cs_n && nv_cs_prev) begin
            nv_frames++;
            nv_cap = '0;
         end
         if (!nv_cs_n && nv_sclk && !nv_sclk_prev) nv_cap = {nv_cap[14:0], nv_mosi};
         nv_cs_prev = nv_cs_n;
         nv_sclk_prev = nv_sclk;
      end
   end

   task automatic push_pass(input int first_idx);
      for (int i = first_idx; i < int'(NREG); i++) begin
         exp_q.push_back(fr(t_addr[i], 1'b0, t_data[i]));
         exp_q.push_back(fr(t_addr[i], 1'b1, 8'h00));
      end
   endtask

   // Called at the falling edge where RESET is released (cycle 0).
   task automatic measure_reset(input string tag);
      int low = 0;
      int first = -1;
      for (int c = 0; c < 200; c++) begin
         if (c != 0) @(negedge clk);
         if (!codec_rst_n) low++;
         if (!cs_n) begin
            first = c;
            break;
         end
      end
      check({tag, "_rst_low_cycles"}, low, 16);
      check({tag, "_first_cs_fall"}, first, 26);
   endtask

   task automatic wait_end(input string tag);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done || error) break;
      end
      check({tag, "_ended"}, 32'(done || error), 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_codec_rst_n"}, 32'(codec_rst_n), 0);
      check({tag, "_cs_n"}, 32'(cs_n), 1);
      check({tag, "_sclk"}, 32'(sclk), 0);
      check({tag, "_mosi"}, 32'(mosi), 0);
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_error"}, 32'(error), 0);
      check({tag, "_err_idx"}, 32'(err_idx), 0);
      check({tag, "_tbl_idx"}, 32'(tbl_idx), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      slave_fault = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");

      // Pass 1: clean write+verify of all entries; a start pulse mid-pass is ignored.
      push_pass(0);
      frames_seen = 0;
      @(negedge clk);
      rst = 1'b0;
      measure_reset("p1");
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("p1_busy_after_start", 32'(busy), 1);
      wait_end("p1");
      check("p1_done", 32'(done), 1);
      check("p1_error", 32'(error), 0);
      check("p1_busy", 32'(busy), 0);
      check("p1_tbl_idx", 32'(tbl_idx), 2);
      check("p1_frames", frames_seen, 6);
      check("p1_queue_empty", exp_q.size(), 0);
      check("nv_done", 32'(nv_done), 1);
      check("nv_error", 32'(nv_error), 0);
      check("nv_frames", nv_frames, 1);
      check("nv_frame_bits", 32'(nv_cap), 32'(fr(7'h11, 1'b0, 8'h5A)));

      // Pass 2: restart from DONE, slave corrupts entry 1 readback.
      slave_fault = 1'b1;
      frames_seen = 0;
      rst_low_seen = 1'b0;
      exp_q.push_back(fr(t_addr[0], 1'b0, t_data[0]));
      exp_q.push_back(fr(t_addr[0], 1'b1, 8'h00));
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(fr(t_addr[1], 1'b0, t_data[1]));
         exp_q.push_back(fr(t_addr[1], 1'b1, 8'h00));
      end
      pulse_start();
      check("p2_restart_tbl_idx", 32'(tbl_idx), 0);
      check("p2_restart_busy", 32'(busy), 1);
      check("p2_restart_done", 32'(done), 0);
      wait_end("p2");
      check("p2_error", 32'(error), 1);
      check("p2_done", 32'(done), 0);
      check("p2_busy", 32'(busy), 0);
      check("p2_err_idx", 32'(err_idx), 1);
      check("p2_tbl_idx", 32'(tbl_idx), 1);
      check("p2_frames", frames_seen, 8);
      check("p2_queue_empty", exp_q.size(), 0);
      check("p2_codec_rst_stayed_high", 32'(rst_low_seen), 0);

      // Pass 3: restart from ERR, then RESET in the middle of the first frame.
      slave_fault = 1'b0;
      pulse_start();
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         #1;
         if (!cs_n && pulses == 5) break;
      end
      check("p3_reached_bit5", pulses, 5);
      abort_frame = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("midframe");
      repeat (2) @(posedge clk);
      push_pass(0);
      frames_seen = 0;
      @(negedge clk);
      rst = 1'b0;
      measure_reset("p3");
      wait_end("p3");
      check("p3_done", 32'(done), 1);
      check("p3_error", 32'(error), 0);
      check("p3_frames", frames_seen, 6);
      check("p3_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
